// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension sequencer.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

  localparam int DIV_CNT_W = $clog2(32);

  // x/0 yields all-ones; x%0 yields the dividend itself.
  localparam logic [63:0] DIVZ_QUO     = '1;
  localparam logic        DIVZ_REM_IS_A = 1'b1;

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module mdu_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem, quo[W-1]};
    diff    = shifted - {1'b0, dvsr};
    // Borrow out means the divisor did not fit: keep the shifted remainder.
    rem_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
    quo_nxt = {quo[W-2:0], ~diff[W]};
  end

endmodule

// File: rtl/mdu_seq_ctrl.sv
// MUL/DIV sequencer: single-cycle multiply, WORD_WIDTH-step restoring divide.
// Define MDU_DIVREM_CACHE_EN to reuse the last divide result for repeated operands.
module mdu_seq_ctrl
  import mdu_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [WORD_WIDTH-1:0] rs1_i,
  input  logic [WORD_WIDTH-1:0] rs2_i,
  input  logic                  kill_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [WORD_WIDTH-1:0] result_o,
  output logic                  stall_o
);

  localparam int W  = WORD_WIDTH;
  localparam int CW = $clog2(WORD_WIDTH);

  mdu_state_e  state;
  mdu_op_e     op;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem_q, quo_q, dvsr_q, rem_nxt, quo_nxt;
  logic          qneg_q, rneg_q, is_rem_q;

  assign op = mdu_op_e'(op_i);

  // Multiplier: sign-extend per op, keep the 2W-bit product.
  logic            mul_a_sgn, mul_b_sgn;
  logic [2*W-1:0]  mul_a, mul_b, prod;
  logic [W-1:0]    mul_res;

  always_comb begin
    mul_a_sgn = (op == OP_MULH) || (op == OP_MULHSU);
    mul_b_sgn = (op == OP_MULH);
    mul_a     = {{W{mul_a_sgn & rs1_i[W-1]}}, rs1_i};
    mul_b     = {{W{mul_b_sgn & rs2_i[W-1]}}, rs2_i};
    prod      = mul_a * mul_b;
    mul_res   = (op == OP_MUL) ? prod[W-1:0] : prod[2*W-1:W];
  end

  // Divide setup: DIV/REM use magnitudes, op_i[0] marks the unsigned forms.
  logic         div_sgn, is_rem, a_neg, b_neg;
  logic [W-1:0] a_mag, b_mag, q_fix, r_fix, divz_res;

  always_comb begin
    div_sgn  = ~op_i[0];
    is_rem   = op_i[1];
    a_neg    = div_sgn & rs1_i[W-1];
    b_neg    = div_sgn & rs2_i[W-1];
    a_mag    = a_neg ? -rs1_i : rs1_i;
    b_mag    = b_neg ? -rs2_i : rs2_i;
    q_fix    = qneg_q ? -quo_q : quo_q;
    r_fix    = rneg_q ? -rem_q : rem_q;
    divz_res = (is_rem && DIVZ_REM_IS_A) ? rs1_i : DIVZ_QUO[W-1:0];
  end

  mdu_div_step #(.W(W)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvsr    (dvsr_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  logic         c_hit;
  logic [W-1:0] hit_res;

`ifdef MDU_DIVREM_CACHE_EN
  logic         accept, c_vld, c_sgn, sgn_q;
  logic [W-1:0] c_a, c_b, c_quo, c_rem, a_q, b_q;

  assign accept  = start_i && ready_o && !kill_i;
  assign c_hit   = c_vld && (c_sgn == div_sgn) && (c_a == rs1_i) && (c_b == rs2_i);
  assign hit_res = is_rem ? c_rem : c_quo;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_vld <= 1'b0;
    end else if (kill_i) begin
      if (state == ST_DIV || state == ST_FIX) c_vld <= 1'b0;
    end else if (accept && !op_i[2]) begin
      c_vld <= 1'b0;
    end else if (state == ST_FIX) begin
      c_vld <= 1'b1;
      c_sgn <= sgn_q;
      c_a   <= a_q;
      c_b   <= b_q;
      c_quo <= q_fix;
      c_rem <= r_fix;
    end
    if (accept) begin
      a_q   <= rs1_i;
      b_q   <= rs2_i;
      sgn_q <= div_sgn;
    end
  end
`else
  assign c_hit   = 1'b0;
  assign hit_res = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      stall_o  <= 1'b0;
      result_o <= '0;
      cnt      <= '0;
    end else if (kill_i) begin
      state    <= ST_IDLE;
      ready_o  <= 1'b1;
      valid_o  <= 1'b0;
      stall_o  <= 1'b0;
      cnt      <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state   <= ST_DONE;
            ready_o <= 1'b1;
            valid_o <= 1'b1;
            stall_o <= 1'b0;
            if (!op_i[2])          result_o <= mul_res;
            else if (rs2_i == '0)  result_o <= divz_res;
            else if (c_hit)        result_o <= hit_res;
            else begin
              state    <= ST_DIV;
              ready_o  <= 1'b0;
              valid_o  <= 1'b0;
              stall_o  <= 1'b1;
              cnt      <= '0;
              rem_q    <= '0;
              quo_q    <= a_mag;
              dvsr_q   <= b_mag;
              qneg_q   <= a_neg ^ b_neg;
              rneg_q   <= a_neg;
              is_rem_q <= is_rem;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DIV: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(W - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          result_o <= is_rem_q ? r_fix : q_fix;
          state    <= ST_DONE;
          ready_o  <= 1'b1;
          valid_o  <= 1'b1;
          stall_o  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
